// File: rtl/axi_rw_split_tracked.sv
// axi_rw_split_tracked
//   Splits one combined AXI read/write slave port into a read-only master
//   (AR/R) and a write-only master (AW/W/B). It tracks outstanding
//   transactions per direction and caps them at MaxReadTxns/MaxWriteTxns.
//   It also provides a quiesce handshake that blocks new AR/AW and drains
//   in-flight traffic. All data paths are zero-latency wires.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous reset, active low
//   slv_req_i        combined slave request
//   slv_resp_o       combined slave response
//   mst_read_req_o   read master request (aw/w fields tied to zero)
//   mst_read_resp_i  read master response
//   mst_write_req_o  write master request (ar field tied to zero)
//   mst_write_resp_i write master response
//   quiesce_i        block new AR/AW and drain outstanding traffic
//   idle_o           drained: nothing outstanding and new AR/AW blocked
//   rd_outstanding_o outstanding read count
//   wr_outstanding_o outstanding write count

package axi_rw_split_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;
endpackage

module axi_rw_split_tracked #(
  parameter type         axi_req_t    = axi_rw_split_pkg::axi_req_t,
  parameter type         axi_resp_t   = axi_rw_split_pkg::axi_resp_t,
  parameter int unsigned MaxReadTxns  = 8,
  parameter int unsigned MaxWriteTxns = 8,
  parameter int unsigned RdCntWidth   = $clog2(MaxReadTxns + 1),
  parameter int unsigned WrCntWidth   = $clog2(MaxWriteTxns + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  axi_req_t              slv_req_i,
  output axi_resp_t             slv_resp_o,
  output axi_req_t              mst_read_req_o,
  input  axi_resp_t             mst_read_resp_i,
  output axi_req_t              mst_write_req_o,
  input  axi_resp_t             mst_write_resp_i,
  input  logic                  quiesce_i,
  output logic                  idle_o,
  output logic [RdCntWidth-1:0] rd_outstanding_o,
  output logic [WrCntWidth-1:0] wr_outstanding_o
);

  localparam logic [RdCntWidth-1:0] RdMax = RdCntWidth'(MaxReadTxns);
  localparam logic [WrCntWidth-1:0] WrMax = WrCntWidth'(MaxWriteTxns);

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_e;

  state_e                  state_reg, state_next;
  logic [RdCntWidth-1:0]   rd_cnt_reg, rd_cnt_next;
  logic [WrCntWidth-1:0]   wr_cnt_reg, wr_cnt_next;
  logic                    ar_lock_reg, ar_lock_next;
  logic                    aw_lock_reg, aw_lock_next;

  logic rd_open, wr_open;
  logic ar_hs, r_last_hs, aw_hs, b_hs;

  // A lock keeps the gate open once a valid has been shown downstream, so a
  // presented AR/AW is never retracted by quiesce or by the limit.
  assign rd_open = ar_lock_reg | ((state_reg == RUN) && (rd_cnt_reg < RdMax));
  assign wr_open = aw_lock_reg | ((state_reg == RUN) && (wr_cnt_reg < WrMax));

  always_comb begin
    mst_read_req_o          = '0;
    mst_read_req_o.ar       = slv_req_i.ar;
    mst_read_req_o.ar_valid = slv_req_i.ar_valid & rd_open;
    mst_read_req_o.r_ready  = slv_req_i.r_ready;

    // W is deliberately ungated: W beats may legally precede their AW.
    mst_write_req_o          = '0;
    mst_write_req_o.aw       = slv_req_i.aw;
    mst_write_req_o.aw_valid = slv_req_i.aw_valid & wr_open;
    mst_write_req_o.w        = slv_req_i.w;
    mst_write_req_o.w_valid  = slv_req_i.w_valid;
    mst_write_req_o.b_ready  = slv_req_i.b_ready;

    slv_resp_o          = '0;
    slv_resp_o.ar_ready = mst_read_resp_i.ar_ready & rd_open;
    slv_resp_o.r_valid  = mst_read_resp_i.r_valid;
    slv_resp_o.r        = mst_read_resp_i.r;
    slv_resp_o.aw_ready = mst_write_resp_i.aw_ready & wr_open;
    slv_resp_o.w_ready  = mst_write_resp_i.w_ready;
    slv_resp_o.b_valid  = mst_write_resp_i.b_valid;
    slv_resp_o.b        = mst_write_resp_i.b;
  end

  assign ar_hs     = mst_read_req_o.ar_valid & mst_read_resp_i.ar_ready;
  assign r_last_hs = mst_read_resp_i.r_valid & slv_req_i.r_ready & mst_read_resp_i.r.last;
  assign aw_hs     = mst_write_req_o.aw_valid & mst_write_resp_i.aw_ready;
  assign b_hs      = mst_write_resp_i.b_valid & slv_req_i.b_ready;

  always_comb begin
    rd_cnt_next  = rd_cnt_reg;
    wr_cnt_next  = wr_cnt_reg;
    ar_lock_next = mst_read_req_o.ar_valid & ~mst_read_resp_i.ar_ready;
    aw_lock_next = mst_write_req_o.aw_valid & ~mst_write_resp_i.aw_ready;
    if (ar_hs && !r_last_hs) rd_cnt_next = rd_cnt_reg + RdCntWidth'(1);
    if (!ar_hs && r_last_hs) rd_cnt_next = rd_cnt_reg - RdCntWidth'(1);
    if (aw_hs && !b_hs)      wr_cnt_next = wr_cnt_reg + WrCntWidth'(1);
    if (!aw_hs && b_hs)      wr_cnt_next = wr_cnt_reg - WrCntWidth'(1);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:   if (quiesce_i) state_next = DRAIN;
      DRAIN: begin
        if (!quiesce_i) state_next = RUN;
        else if (rd_cnt_reg == '0 && wr_cnt_reg == '0 && !ar_lock_reg && !aw_lock_reg)
          state_next = IDLE;
      end
      IDLE:  if (!quiesce_i) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= RUN;
      rd_cnt_reg  <= '0;
      wr_cnt_reg  <= '0;
      ar_lock_reg <= 1'b0;
      aw_lock_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_cnt_reg  <= rd_cnt_next;
      wr_cnt_reg  <= wr_cnt_next;
      ar_lock_reg <= ar_lock_next;
      aw_lock_reg <= aw_lock_next;
    end
  end

  assign idle_o           = (state_reg == IDLE);
  assign rd_outstanding_o = rd_cnt_reg;
  assign wr_outstanding_o = wr_cnt_reg;

  // Response fields that belong to the other direction are intentionally ignored.
  logic unused_resp;
  assign unused_resp = ^{mst_read_resp_i.aw_ready, mst_read_resp_i.w_ready,
                         mst_read_resp_i.b_valid, mst_read_resp_i.b,
                         mst_write_resp_i.ar_ready, mst_write_resp_i.r_valid,
                         mst_write_resp_i.r};

`ifndef SYNTHESIS
  a_no_r_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_last_hs && !ar_hs |-> rd_cnt_reg != '0);
  a_no_b_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    b_hs && !aw_hs |-> wr_cnt_reg != '0);
  a_no_rd_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ar_hs && !r_last_hs |-> rd_cnt_reg < RdMax);
  a_no_wr_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    aw_hs && !b_hs |-> wr_cnt_reg < WrMax);
  a_no_b_on_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !mst_read_resp_i.b_valid);
  a_no_r_on_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !mst_write_resp_i.r_valid);
`endif

endmodule

// File: tb/tb_axi_rw_split_tracked.sv
// Directed bench for axi_rw_split_tracked with both limits set to 2.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_axi_rw_split_tracked;
  import axi_rw_split_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  axi_req_t  slv_req;
  axi_resp_t slv_resp;
  axi_req_t  rd_req;
  axi_resp_t rd_resp;
  axi_req_t  wr_req;
  axi_resp_t wr_resp;
  logic      quiesce;
  logic      idle;
  logic [1:0] rd_out;
  logic [1:0] wr_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_rw_split_tracked #(
    .MaxReadTxns (2),
    .MaxWriteTxns(2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .slv_req_i       (slv_req),
    .slv_resp_o      (slv_resp),
    .mst_read_req_o  (rd_req),
    .mst_read_resp_i (rd_resp),
    .mst_write_req_o (wr_req),
    .mst_write_resp_i(wr_resp),
    .quiesce_i       (quiesce),
    .idle_o          (idle),
    .rd_outstanding_o(rd_out),
    .wr_outstanding_o(wr_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance one full clock and land on the next falling edge, then settle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    slv_req = '0;
    rd_resp = '0;
    wr_resp = '0;
    quiesce = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_idle", idle, 0);
    check_eq("rst_rd_out", rd_out, 0);
    check_eq("rst_wr_out", wr_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three back-to-back ARs against a limit of 2
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = 32'h100;
    rd_resp.ar_ready = 1'b1;
    #1;
    check_eq("t1_ar_ready0", slv_resp.ar_ready, 1);
    check_eq("t1_mst_ar_valid0", rd_req.ar_valid, 1);
    check_eq("t1_ar_addr", rd_req.ar.addr, 32'h100);
    check_eq("t1_wr_ar_tied", wr_req.ar_valid, 0);
    step(); #1;
    check_eq("t1_rd_out1", rd_out, 1);
    check_eq("t1_ar_ready1", slv_resp.ar_ready, 1);
    step(); #1;
    check_eq("t1_rd_out2", rd_out, 2);
    check_eq("t1_ar_ready_full", slv_resp.ar_ready, 0);
    check_eq("t1_mst_ar_valid_full", rd_req.ar_valid, 0);
    step(); #1;
    check_eq("t1_rd_out_hold", rd_out, 2);
    check_eq("t1_ar_ready_hold", slv_resp.ar_ready, 0);

    // R last in the same cycle as a pending AR at the limit
    rd_resp.r_valid  = 1'b1;
    rd_resp.r.last   = 1'b1;
    rd_resp.r.data   = 32'hABCD;
    slv_req.r_ready  = 1'b1;
    #1;
    check_eq("t2_r_valid", slv_resp.r_valid, 1);
    check_eq("t2_r_data", slv_resp.r.data, 32'hABCD);
    check_eq("t2_ar_ready_same", slv_resp.ar_ready, 0);
    step();
    rd_resp.r_valid = 1'b0;
    #1;
    check_eq("t2_rd_out_dec", rd_out, 1);
    check_eq("t2_ar_ready_next", slv_resp.ar_ready, 1);
    step();
    slv_req.ar_valid = 1'b0;
    #1;
    check_eq("t2_rd_out_back", rd_out, 2);
    rd_resp.r_valid = 1'b1;
    step(); step();
    rd_resp.r_valid = 1'b0;
    #1;
    check_eq("t2_rd_drained", rd_out, 0);

    // W ahead of AW, then two AWs
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 32'h55AA;
    wr_resp.w_ready  = 1'b1;
    #1;
    check_eq("t5_w_valid", wr_req.w_valid, 1);
    check_eq("t5_w_data", wr_req.w.data, 32'h55AA);
    check_eq("t5_w_ready", slv_resp.w_ready, 1);
    check_eq("t5_rd_w_tied", rd_req.w_valid, 0);
    check_eq("t5_wr_out0", wr_out, 0);
    step();
    slv_req.w_valid  = 1'b0;
    slv_req.aw_valid = 1'b1;
    wr_resp.aw_ready = 1'b1;
    #1;
    check_eq("t5_aw_valid", wr_req.aw_valid, 1);
    step(); #1;
    check_eq("t5_wr_out1", wr_out, 1);
    step(); #1;
    check_eq("t5_wr_out2", wr_out, 2);

    // Quiesce with two writes outstanding
    quiesce = 1'b1;
    #1;
    check_eq("t3_aw_blocked", wr_req.aw_valid, 0);
    step(); #1;
    check_eq("t3_idle_drain", idle, 0);
    wr_resp.b_valid = 1'b1;
    wr_resp.b.resp  = 2'b10;
    slv_req.b_ready = 1'b1;
    #1;
    check_eq("t3_b_valid", slv_resp.b_valid, 1);
    check_eq("t3_b_resp", slv_resp.b.resp, 2);
    check_eq("t3_rd_b_ready_tied", rd_req.b_ready, 0);
    step(); #1;
    check_eq("t3_wr_out1", wr_out, 1);
    check_eq("t3_aw_blocked_drain", wr_req.aw_valid, 0);
    step();
    wr_resp.b_valid = 1'b0;
    #1;
    check_eq("t3_wr_out0", wr_out, 0);
    check_eq("t3_idle_not_yet", idle, 0);
    step(); #1;
    check_eq("t3_idle_up", idle, 1);
    check_eq("t3_aw_blocked_idle", wr_req.aw_valid, 0);
    quiesce = 1'b0;
    step(); #1;
    check_eq("t3_idle_down", idle, 0);
    check_eq("t3_aw_flows", wr_req.aw_valid, 1);
    step();
    slv_req.aw_valid = 1'b0;
    #1;
    check_eq("t3_wr_out_after", wr_out, 1);
    wr_resp.b_valid = 1'b1;
    step();
    wr_resp.b_valid = 1'b0;
    #1;
    check_eq("t3_wr_cleared", wr_out, 0);

    // AR stalled downstream, then quiesce must not retract it
    rd_resp.ar_ready = 1'b0;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = 32'h200;
    #1;
    check_eq("t4_ar_valid", rd_req.ar_valid, 1);
    step();
    quiesce = 1'b1;
    #1;
    check_eq("t4_ar_held", rd_req.ar_valid, 1);
    check_eq("t4_ar_ready_stall", slv_resp.ar_ready, 0);
    step(); #1;
    check_eq("t4_ar_held_drain", rd_req.ar_valid, 1);
    check_eq("t4_rd_out0", rd_out, 0);
    step(); #1;
    check_eq("t4_idle_locked", idle, 0);
    rd_resp.ar_ready = 1'b1;
    step();
    slv_req.ar_valid = 1'b0;
    #1;
    check_eq("t4_rd_out1", rd_out, 1);
    slv_req.ar_valid = 1'b1;
    #1;
    check_eq("t4_new_ar_blocked", rd_req.ar_valid, 0);
    slv_req.ar_valid = 1'b0;
    step(); #1;
    check_eq("t4_idle_pending", idle, 0);
    rd_resp.r_valid = 1'b1;
    step();
    rd_resp.r_valid = 1'b0;
    #1;
    check_eq("t4_rd_out0_end", rd_out, 0);
    step(); #1;
    check_eq("t4_idle_up", idle, 1);
    quiesce = 1'b0;
    step(); #1;
    check_eq("t4_idle_down", idle, 0);

    // Reset while draining with traffic outstanding
    slv_req.ar_valid = 1'b1;
    slv_req.aw_valid = 1'b1;
    step();
    slv_req.aw_valid = 1'b0;
    step();
    slv_req.ar_valid = 1'b0;
    quiesce = 1'b1;
    #1;
    check_eq("t6_rd_pre", rd_out, 2);
    check_eq("t6_wr_pre", wr_out, 1);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("t6_rd_rst", rd_out, 0);
    check_eq("t6_wr_rst", wr_out, 0);
    check_eq("t6_idle_rst", idle, 0);
    step();
    quiesce = 1'b0;
    rst_n = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.aw_valid = 1'b1;
    #1;
    check_eq("t6_ar_open", rd_req.ar_valid, 1);
    check_eq("t6_aw_open", wr_req.aw_valid, 1);
    step();
    slv_req.ar_valid = 1'b0;
    slv_req.aw_valid = 1'b0;
    #1;
    check_eq("t6_rd_after", rd_out, 1);
    check_eq("t6_wr_after", wr_out, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
